// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock-divider controller: FSM states and default sizing.
package clkdiv_pkg;

  localparam int C_CNT_WIDTH   = 8;
  localparam int C_DEFAULT_DIV = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/clkdiv_counter.sv
// Half-period counter: counts to i_div, then toggles the registered clock and pulses tick.
// Counter is one bit wider than the divide word so a divide of all-ones never wraps early.
module clkdiv_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_div,
  output logic                 o_clk_out,
  output logic                 o_tick,
  output logic                 o_tc
);

  logic [CNT_WIDTH:0] r_cnt;
  logic               r_clk_out;
  logic               r_tick;
  logic               w_tc;

  assign w_tc      = i_en && (r_cnt == {1'b0, i_div});
  assign o_tc      = w_tc;
  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!i_en) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else if (w_tc) begin
      r_cnt     <= '0;
      r_clk_out <= ~r_clk_out;
      r_tick    <= 1'b1;
    end else begin
      r_cnt     <= r_cnt + (CNT_WIDTH+1)'(1);
      r_tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/clkdiv_ctrl.sv
// Clock-divider controller: run/stop FSM plus a one-deep pending register for divide updates.
// Divide changes only take effect at a terminal count, so every half-period uses a single value.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = C_CNT_WIDTH,
  parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  output logic                 cfg_ready,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] cur_div
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cur_div;
  logic [CNT_WIDTH-1:0] r_pend_div;
  logic                 r_pend_vld;
  logic                 w_tc;
  logic                 w_clk_out;
  logic                 w_tick;
  logic                 w_en;
  logic                 w_accept;
  logic                 w_load;

  assign w_en      = (r_state != IDLE);
  assign w_accept  = cfg_valid && !r_pend_vld;
  assign w_load    = r_pend_vld && ((r_state == IDLE) || w_tc);

  assign cfg_ready = ~r_pend_vld;
  assign active    = w_en;
  assign cur_div   = r_cur_div;
  assign clk_out   = w_clk_out;
  assign tick      = w_tick;

  clkdiv_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clk_in    (clk_in),
    .rst       (rst),
    .i_en      (w_en),
    .i_div     (r_cur_div),
    .o_clk_out (w_clk_out),
    .o_tick    (w_tick),
    .o_tc      (w_tc)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stopping only ends on the terminal count that brings clk_out low.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (run) w_state_nxt = RUN;
      RUN:      if (!run) w_state_nxt = STOPPING;
      STOPPING: begin
        if (run) begin
          w_state_nxt = RUN;
        end else if (w_tc && w_clk_out) begin
          w_state_nxt = IDLE;
        end
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cur_div  <= CNT_WIDTH'(DEFAULT_DIV);
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_load) begin
        r_cur_div  <= r_pend_div;
        r_pend_vld <= 1'b0;
      end
      if (w_accept) begin
        r_pend_div <= cfg_div;
        r_pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Bench for clkdiv_ctrl: directed scenarios plus random run/config traffic vs a countdown model.
module tb_clkdiv_ctrl;

  logic       clk_in;
  logic       rst;
  logic       run;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       clk_out;
  logic       tick;
  logic       active;
  logic [7:0] cur_div;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: cycles remaining until the next clk_out edge.
  bit m_on, m_stopping, m_level, m_tick, m_pend;
  int m_left, m_div, m_pend_div;

  clkdiv_ctrl dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .active    (active),
    .cur_div   (cur_div)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_stopping = 0; m_level = 0; m_tick = 0;
    m_pend = 0; m_pend_div = 0; m_div = 3; m_left = 0;
  endtask

  task automatic model_edge();
    bit acc, term, old_level;
    if (rst) begin
      model_reset();
      return;
    end
    acc = cfg_valid && !m_pend;
    if (!m_on) begin
      m_tick  = 0;
      m_level = 0;
      if (m_pend) begin m_div = m_pend_div; m_pend = 0; end
      if (run) begin m_on = 1; m_stopping = 0; m_left = m_div + 1; end
    end else begin
      m_left    = m_left - 1;
      term      = (m_left == 0);
      old_level = m_level;
      m_tick    = term;
      if (term) begin
        m_level = !m_level;
        if (m_pend) begin m_div = m_pend_div; m_pend = 0; end
        m_left = m_div + 1;
      end
      if (m_stopping && !run && term && old_level) begin
        m_on = 0; m_stopping = 0;
      end else begin
        m_stopping = !run;
      end
    end
    if (acc) begin m_pend = 1; m_pend_div = int'(cfg_div); end
  endtask

  task automatic compare_all();
    chk("clk_out", clk_out, m_level);
    chk("tick", tick, m_tick);
    chk("active", active, m_on);
    chk("cfg_ready", cfg_ready, !m_pend);
    chk("cur_div", cur_div, m_div);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    compare_all();
  endtask

  // Returns number of edges taken until tick is seen; a timeout counts as a failure.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 1000);
    if (!tick) chk("tick_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    #2 rst = 1'b0;
  endtask

  task automatic write_cfg(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, ticks;
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #2 compare_all();
    chk("rst_cur_div", cur_div, 3);
    chk("rst_ready", cfg_ready, 1);
    step(); step();
    #2 rst = 1'b0;
    step();

    // Default divide: first tick 4 edges after run is sampled, 8-cycle period.
    run = 1'b1;
    step();
    wait_tick(n);  chk("first_tick", n, 4);
    chk("first_rise", clk_out, 1);
    wait_tick(n);  chk("high_half", n, 4);
    chk("fall", clk_out, 0);
    wait_tick(n);  chk("low_half", n, 4);

    // Divide 0 written mid-high phase.
    step();
    write_cfg(8'd0);
    chk("rdy_low", cfg_ready, 0);
    wait_tick(n);  chk("high_complete", n, 2);
    chk("rdy_back", cfg_ready, 1);
    chk("div0_loaded", cur_div, 0);
    wait_tick(n);  chk("div0_half_a", n, 1);
    wait_tick(n);  chk("div0_half_b", n, 1);

    // Divide 5 offered exactly on a terminal count.
    write_cfg(8'd3);
    wait_tick(n);
    wait_tick(n);
    chk("div3_loaded", cur_div, 3);
    wait_tick(n);
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    chk("tc_coincide_tick", tick, 1);
    wait_tick(n);  chk("still_div3", n, 4);
    wait_tick(n);  chk("div5_half_a", n, 6);
    wait_tick(n);  chk("div5_half_b", n, 6);

    // Stop while high, then resume from STOPPING without a phase glitch.
    if (!clk_out) wait_tick(n);
    step();
    run = 1'b0;
    wait_tick(n);
    chk("stop_low", clk_out, 0);
    chk("stop_idle", active, 0);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      ticks += int'(tick);
    end
    chk("no_ticks_idle", ticks, 0);
    run = 1'b1;
    step();
    wait_tick(n);  chk("restart_tick", n, 6);
    run = 1'b0;
    step(); step();
    run = 1'b1;
    wait_tick(n);  chk("resume_phase", n, 4);
    chk("resume_active", active, 1);

    // Reset mid-period with a configuration pending.
    step(); step();
    write_cfg(8'd7);
    chk("pend_set", cfg_ready, 0);
    do_reset();
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_div", cur_div, 3);
    chk("rst_rdy", cfg_ready, 1);
    run = 1'b0;
    step(); step();
    chk("rst_inactive", active, 0);

    // Largest divide: 256-cycle half-periods.
    write_cfg(8'd255);
    step();
    chk("div255", cur_div, 255);
    run = 1'b1;
    step();
    wait_tick(n);  chk("half255_a", n, 256);
    wait_tick(n);  chk("half255_b", n, 256);
    run = 1'b0;
    wait_tick(n);  wait_tick(n);
    if (clk_out || active) wait_tick(n);
    chk("idle255", active, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
